// File: rtl/drac_pkg.sv
// Shared DRAC pipeline types used by the graduation list.
package drac_pkg;

  localparam int GL_NUM_ENTRIES = 8;
  localparam int GL_TAG_W       = $clog2(GL_NUM_ENTRIES);

  typedef logic [GL_TAG_W-1:0] gl_tag_t;

  // One in-flight instruction slot at default pipeline widths.
  typedef struct packed {
    logic        valid;
    logic        done;
    logic [63:0] pc;
    logic [4:0]  rd;
    logic        we;
    logic [63:0] data;
    logic        xcpt;
    logic [63:0] cause;
  } gl_entry_t;

endpackage

// File: rtl/graduation_list.sv
// In-order retirement buffer: allocate at issue, complete out of order by
// tag, retire from the head; an exception at the head empties the list.
module graduation_list
  import drac_pkg::*;
#(
  parameter int NUM_ENTRIES = GL_NUM_ENTRIES,
  parameter int DATA_W      = 64,
  parameter int PC_W        = 64,
  parameter int REG_W       = 5,
  parameter int CAUSE_W     = 64,
  parameter int TAG_W       = $clog2(NUM_ENTRIES)
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               flush_i,
  input  logic               ins_valid_i,
  input  logic [PC_W-1:0]    ins_pc_i,
  input  logic [REG_W-1:0]   ins_rd_i,
  input  logic               ins_we_i,
  output logic               ins_ready_o,
  output logic [TAG_W-1:0]   ins_tag_o,
  input  logic               cmp_valid_i,
  input  logic [TAG_W-1:0]   cmp_tag_i,
  input  logic [DATA_W-1:0]  cmp_data_i,
  input  logic               cmp_xcpt_i,
  input  logic [CAUSE_W-1:0] cmp_cause_i,
  output logic               commit_valid_o,
  input  logic               commit_ack_i,
  output logic [PC_W-1:0]    commit_pc_o,
  output logic [REG_W-1:0]   commit_rd_o,
  output logic               commit_we_o,
  output logic [DATA_W-1:0]  commit_data_o,
  output logic               commit_xcpt_o,
  output logic [CAUSE_W-1:0] commit_cause_o,
  output logic               xcpt_flush_o,
  output logic [TAG_W:0]     count_o,
  output logic               empty_o
);

  localparam logic [TAG_W:0] CNT_FULL = (TAG_W+1)'(NUM_ENTRIES);

  // Payload carries no reset; it is only meaningful while its valid bit is set.
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [REG_W-1:0]   rd;
    logic               we;
    logic [DATA_W-1:0]  data;
    logic               xcpt;
    logic [CAUSE_W-1:0] cause;
  } payload_t;

  payload_t               pay_q [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] valid_q;
  logic [NUM_ENTRIES-1:0] done_q;
  logic [TAG_W-1:0]       head_q;
  logic [TAG_W-1:0]       tail_q;
  logic [TAG_W:0]         count_q;
  logic                   xcpt_flush_q;

  logic alloc;
  logic cmp_hit;
  logic commit;
  logic xcpt_commit;
  logic clear_all;

  // Ready looks only at the current count, so a same-cycle commit never
  // frees a slot for that cycle's allocation.
  assign ins_ready_o = (count_q < CNT_FULL);
  assign ins_tag_o   = tail_q;
  assign alloc       = ins_valid_i && ins_ready_o;
  assign cmp_hit     = cmp_valid_i && valid_q[cmp_tag_i];

  assign commit_valid_o = valid_q[head_q] && done_q[head_q];
  assign commit_pc_o    = pay_q[head_q].pc;
  assign commit_rd_o    = pay_q[head_q].rd;
  assign commit_we_o    = pay_q[head_q].we && !pay_q[head_q].xcpt;
  assign commit_data_o  = pay_q[head_q].data;
  assign commit_xcpt_o  = pay_q[head_q].xcpt;
  assign commit_cause_o = pay_q[head_q].cause;

  // External flush overrides everything, including the commit itself.
  assign commit      = commit_valid_o && commit_ack_i && !flush_i;
  assign xcpt_commit = commit && pay_q[head_q].xcpt;
  assign clear_all   = flush_i || xcpt_commit;

  assign xcpt_flush_o = xcpt_flush_q;
  assign count_o      = count_q;
  assign empty_o      = (count_q == '0);

  // Per-entry valid/done flags: completion, then head retire, then tail alloc.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_q <= '0;
      done_q  <= '0;
    end else if (clear_all) begin
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      if (cmp_hit) done_q[cmp_tag_i] <= 1'b1;
      if (commit)  valid_q[head_q]   <= 1'b0;
      if (alloc) begin
        valid_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= 1'b0;
      end
    end
  end

  // Head/tail pointers wrap naturally; count disambiguates full from empty.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (clear_all) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (commit) head_q <= head_q + 1'b1;
      if (alloc)  tail_q <= tail_q + 1'b1;
      count_q <= count_q + (TAG_W+1)'(alloc) - (TAG_W+1)'(commit);
    end
  end

  // One-cycle pulse after an exception retires; external flush does not raise it.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) xcpt_flush_q <= 1'b0;
    else         xcpt_flush_q <= xcpt_commit;
  end

  // Payload capture at allocation and at completion.
  always_ff @(posedge clk_i) begin
    if (alloc) begin
      pay_q[tail_q].pc <= ins_pc_i;
      pay_q[tail_q].rd <= ins_rd_i;
      pay_q[tail_q].we <= ins_we_i;
    end
    if (cmp_hit) begin
      pay_q[cmp_tag_i].data  <= cmp_data_i;
      pay_q[cmp_tag_i].xcpt  <= cmp_xcpt_i;
      pay_q[cmp_tag_i].cause <= cmp_cause_i;
    end
  end

  // Execute units must only complete tags that are in flight.
  cmp_tag_live: assert property (@(posedge clk_i) disable iff (!rstn_i)
    (cmp_valid_i && !flush_i) |-> valid_q[cmp_tag_i]);

endmodule
